// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard scoreboard slot format and register-select width.
package cpu_pkg;

   localparam int NUM_HZ_SLOTS = 3;
   localparam int REG_SEL_W    = 3;

   typedef struct packed {
      logic                 valid;
      logic [REG_SEL_W-1:0] sel;
   } hz_slot_t;

   function automatic logic slot_hit(input hz_slot_t s, input logic [REG_SEL_W-1:0] r);
      return s.valid && (s.sel == r);
   endfunction

endpackage

// File: rtl/dff.sv
// Generic W-bit D flip-flop with synchronous active-high reset to zero.
module dff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else     q <= d;
   end

endmodule

// File: rtl/hz_slot.sv
// One scoreboard slot {valid, sel}: holds its value while en is low, clears on reset.
module hz_slot
   import cpu_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     en,
   input  hz_slot_t d,
   output hz_slot_t q
);

   logic [$bits(hz_slot_t)-1:0] d_bits;
   logic [$bits(hz_slot_t)-1:0] q_bits;

   assign d_bits = en ? d : q;
   assign q      = q_bits;

   dff #(.W($bits(hz_slot_t))) u_dff (
      .clk (clk),
      .rst (rst),
      .d   (d_bits),
      .q   (q_bits)
   );

endmodule

// File: rtl/reg_hazard_ctrl.sv
// Decode-side RAW hazard controller: tracks EX/MEM/WB destinations, stalls decode,
// inserts execute bubbles and counts stall cycles.
module reg_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REG_SEL_W-1:0] id_rs_sel,
   input  logic                 id_rs_used,
   input  logic [REG_SEL_W-1:0] id_rt_sel,
   input  logic                 id_rt_used,
   input  logic                 id_wr_en,
   input  logic [REG_SEL_W-1:0] id_wr_sel,
   input  logic                 flush,
   input  logic                 hold,
   output logic                 stall,
   output logic                 ifid_wr_en,
   output logic                 ex_bubble,
   output logic [CNT_W-1:0]     stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // index 0 = EX, 1 = MEM, 2 = WB
   hz_slot_t slot_d [NUM_HZ_SLOTS];
   hz_slot_t slot_q [NUM_HZ_SLOTS];
   hz_slot_t ex_d;
   logic     hit_rs;
   logic     hit_rt;
   logic     hazard;

   // No register-file bypass, so the WB slot counts as a hazard too.
   always_comb begin
      hit_rs = 1'b0;
      hit_rt = 1'b0;
      for (int i = 0; i < NUM_HZ_SLOTS; i++) begin
         hit_rs = hit_rs | slot_hit(slot_q[i], id_rs_sel);
         hit_rt = hit_rt | slot_hit(slot_q[i], id_rt_sel);
      end
      hazard     = ~rst & id_valid & ((id_rs_used & hit_rs) | (id_rt_used & hit_rt));
      stall      = hazard & ~flush;
      ifid_wr_en = ~stall & ~hold;
      ex_bubble  = stall | flush | ~id_valid;
      ex_d.valid = id_valid & id_wr_en & ~stall & ~flush;
      ex_d.sel   = id_wr_sel;
   end

   always_comb begin
      slot_d[0] = ex_d;
      for (int i = 1; i < NUM_HZ_SLOTS; i++) slot_d[i] = slot_q[i-1];
   end

   for (genvar g = 0; g < NUM_HZ_SLOTS; g++) begin : g_slot
      hz_slot u_slot (
         .clk (clk),
         .rst (rst),
         .en  (~hold),
         .d   (slot_d[g]),
         .q   (slot_q[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall && !hold && stall_cnt != CNT_MAX)
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// Directed bench for reg_hazard_ctrl with hand-computed stall counts (CNT_W = 4).
module tb_reg_hazard_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             id_valid;
   logic [2:0]       id_rs_sel;
   logic             id_rs_used;
   logic [2:0]       id_rt_sel;
   logic             id_rt_used;
   logic             id_wr_en;
   logic [2:0]       id_wr_sel;
   logic             flush;
   logic             hold;
   logic             stall;
   logic             ifid_wr_en;
   logic             ex_bubble;
   logic [CNT_W-1:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_rs_sel  (id_rs_sel),
      .id_rs_used (id_rs_used),
      .id_rt_sel  (id_rt_sel),
      .id_rt_used (id_rt_used),
      .id_wr_en   (id_wr_en),
      .id_wr_sel  (id_wr_sel),
      .flush      (flush),
      .hold       (hold),
      .stall      (stall),
      .ifid_wr_en (ifid_wr_en),
      .ex_bubble  (ex_bubble),
      .stall_cnt  (stall_cnt)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_idle();
      id_valid   = 1'b0;
      id_rs_sel  = 3'd0;
      id_rs_used = 1'b0;
      id_rt_sel  = 3'd0;
      id_rt_used = 1'b0;
      id_wr_en   = 1'b0;
      id_wr_sel  = 3'd0;
      flush      = 1'b0;
      hold       = 1'b0;
   endtask

   task automatic set_id(input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                         input logic rtu, input logic we, input logic [2:0] ws);
      id_valid   = 1'b1;
      id_rs_sel  = rs;
      id_rs_used = rsu;
      id_rt_sel  = rt;
      id_rt_used = rtu;
      id_wr_en   = we;
      id_wr_sel  = ws;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Counts stall cycles for the instruction now in decode, then lets it advance.
   task automatic run_stalls(input string tag, output int n, output int nb);
      n  = 0;
      nb = 0;
      #1;
      while (stall === 1'b1 && n < 20) begin
         n++;
         if (ex_bubble === 1'b1) nb++;
         tick();
         #1;
      end
      if (n >= 20) check_eq({tag, "_timeout"}, n, 0);
      tick();
   endtask

   initial begin
      int n, nb, total;
      int exp_d [1:4];
      exp_d = '{3, 2, 1, 0};

      // Reset behaviour
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      tick();
      #1;
      check_eq("rst_stall", int'(stall), 0);
      check_eq("rst_ifid", int'(ifid_wr_en), 1);
      check_eq("rst_bubble", int'(ex_bubble), 1);
      hold = 1'b1;
      #1;
      check_eq("rst_ifid_hold", int'(ifid_wr_en), 0);
      hold = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      check_eq("rst_cnt", int'(stall_cnt), 0);
      set_id(3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 3'd0);
      #1;
      check_eq("empty_no_stall", int'(stall), 0);
      check_eq("valid_no_bubble", int'(ex_bubble), 0);

      // Back-to-back RAW on rs
      do_reset();
      set_id(3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd3);
      tick();
      set_id(3'd3, 1'b1, 3'd5, 1'b1, 1'b1, 3'd4);
      run_stalls("b2b", n, nb);
      check_eq("b2b_stalls", n, 3);
      check_eq("b2b_bubbles", nb, 3);
      set_idle();
      #1;
      check_eq("b2b_cnt", int'(stall_cnt), 3);

      // Distance sweep on the rt port
      for (int d = 1; d <= 4; d++) begin
         do_reset();
         set_id(3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd5);
         tick();
         for (int k = 1; k < d; k++) begin
            set_id(3'd6, 1'b1, 3'd7, 1'b0, 1'b1, 3'd4);
            #1;
            check_eq("indep_no_stall", int'(stall), 0);
            tick();
         end
         set_id(3'd3, 1'b1, 3'd5, 1'b1, 1'b1, 3'd6);
         run_stalls("dist", n, nb);
         check_eq($sformatf("dist%0d_stalls", d), n, exp_d[d]);
      end

      // Distance 2 but rt not used
      do_reset();
      set_id(3'd1, 1'b1, 3'd3, 1'b1, 1'b1, 3'd2);
      tick();
      set_id(3'd6, 1'b1, 3'd7, 1'b0, 1'b1, 3'd4);
      tick();
      set_id(3'd1, 1'b1, 3'd2, 1'b0, 1'b1, 3'd6);
      run_stalls("rt_unused", n, nb);
      check_eq("rt_unused_stalls", n, 0);

      // Flush in the second stall cycle
      do_reset();
      set_id(3'd1, 1'b1, 3'd3, 1'b1, 1'b1, 3'd2);
      tick();
      set_id(3'd2, 1'b1, 3'd0, 1'b0, 1'b1, 3'd5);
      #1;
      check_eq("flush_pre_stall", int'(stall), 1);
      tick();
      flush = 1'b1;
      #1;
      check_eq("flush_stall", int'(stall), 0);
      check_eq("flush_bubble", int'(ex_bubble), 1);
      check_eq("flush_ifid", int'(ifid_wr_en), 1);
      tick();
      flush = 1'b0;
      set_id(3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0);
      #1;
      check_eq("flush_ex_empty", int'(stall), 0);
      check_eq("flush_cnt", int'(stall_cnt), 1);

      // Hold during a distance-1 hazard
      do_reset();
      set_id(3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd3);
      tick();
      set_id(3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4);
      #1;
      check_eq("hold_pre_stall", int'(stall), 1);
      hold = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_eq("hold_stall", int'(stall), 1);
         check_eq("hold_ifid", int'(ifid_wr_en), 0);
         tick();
      end
      check_eq("hold_cnt", int'(stall_cnt), 0);
      hold = 1'b0;
      run_stalls("hold", n, nb);
      check_eq("hold_stalls_after", n, 3);
      set_idle();
      #1;
      check_eq("hold_cnt_after", int'(stall_cnt), 3);

      // JAL then JR r7, and an r6 reader
      do_reset();
      set_id(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd7);
      tick();
      set_id(3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0);
      run_stalls("jr", n, nb);
      check_eq("jr_stalls", n, 3);
      do_reset();
      set_id(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd7);
      tick();
      set_id(3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0);
      run_stalls("r6", n, nb);
      check_eq("r6_stalls", n, 0);

      // R0 is tracked like any register
      do_reset();
      set_id(3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd0);
      tick();
      set_id(3'd0, 1'b1, 3'd4, 1'b1, 1'b1, 3'd3);
      run_stalls("r0", n, nb);
      check_eq("r0_stalls", n, 3);

      // Saturation: six chained RAWs give 18 stall cycles, counter stops at 15
      do_reset();
      set_id(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1);
      tick();
      total = 0;
      for (int k = 0; k < 6; k++) begin
         set_id(3'(k + 1), 1'b1, 3'd0, 1'b0, 1'b1, 3'(k + 2));
         run_stalls("chain", n, nb);
         total += n;
      end
      check_eq("chain_total", total, 18);
      set_idle();
      #1;
      check_eq("sat_cnt", int'(stall_cnt), 15);

      // Reset mid-stall
      set_id(3'd7, 1'b1, 3'd0, 1'b0, 1'b1, 3'd1);
      #1;
      check_eq("midrst_pre_stall", int'(stall), 1);
      rst = 1'b1;
      #1;
      check_eq("midrst_rst_stall", int'(stall), 0);
      tick();
      rst = 1'b0;
      #1;
      check_eq("midrst_stall", int'(stall), 0);
      check_eq("midrst_cnt", int'(stall_cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
